// File: rtl/way_halt_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : way_halt_controller_if
// Brief    : Request/response, halt-array and refill signals of the controller
// Revision : 1.0
// ---------------------------------------------------------------------------
interface way_halt_controller_if #(
   parameter int TAG_W  = 12,
   parameter int HALT_W = 4,
   parameter int WAYS   = 8
);
   localparam int c_WAY_W = $clog2(WAYS);

   logic                req_valid;
   logic                req_ready;
   logic [TAG_W-1:0]    req_tag;
   logic                flush;
   logic [HALT_W-1:0]   halt_tag;
   logic [WAYS-1:0]     halt_flag;
   logic [WAYS-1:0]     we;
   logic [HALT_W-1:0]   halt_tag_write;
   logic [WAYS-1:0]     way_en;
   logic                resp_valid;
   logic                resp_hit;
   logic [c_WAY_W-1:0]  resp_way;
   logic                mem_req;
   logic [TAG_W-1:0]    mem_tag;
   logic                mem_ack;

   modport master (
      output req_valid, req_tag, flush, halt_flag, mem_ack,
      input  req_ready, halt_tag, we, halt_tag_write, way_en,
             resp_valid, resp_hit, resp_way, mem_req, mem_tag
   );

   modport slave (
      input  req_valid, req_tag, flush, halt_flag, mem_ack,
      output req_ready, halt_tag, we, halt_tag_write, way_en,
             resp_valid, resp_hit, resp_way, mem_req, mem_tag
   );
endinterface
`default_nettype wire

// File: rtl/way_halt_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : way_halt_controller
// Brief    : Halt-tag filtered lookup, refill handshake and victim writeback
// Revision : 1.0
// ---------------------------------------------------------------------------
module way_halt_controller #(
   parameter int TAG_W  = 12,
   parameter int HALT_W = 4,
   parameter int WAYS   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   way_halt_controller_if.slave bus
);
   localparam int c_WAY_W = $clog2(WAYS);

   localparam logic [2:0] c_IDLE     = 3'd0;
   localparam logic [2:0] c_LOOKUP   = 3'd1;
   localparam logic [2:0] c_MISS_REQ = 3'd2;
   localparam logic [2:0] c_FILL     = 3'd3;
   localparam logic [2:0] c_RESP     = 3'd4;

   logic [2:0]          r_state;
   logic [2:0]          w_next_state;
   logic [TAG_W-1:0]    r_tag_ram [WAYS];
   logic [WAYS-1:0]     r_valid;
   logic [c_WAY_W-1:0]  r_rr_ptr;
   logic [TAG_W-1:0]    r_latched_tag;
   logic                r_resp_hit;
   logic [c_WAY_W-1:0]  r_resp_way;

   logic [WAYS-1:0]     w_cand;
   logic                w_hit;
   logic [c_WAY_W-1:0]  w_hit_way;
   logic                w_any_free;
   logic [c_WAY_W-1:0]  w_free_way;
   logic [c_WAY_W-1:0]  w_victim;

   // Descending scans so the lowest matching index is the one left standing.
   always_comb begin
      w_cand     = bus.halt_flag & r_valid;
      w_hit      = 1'b0;
      w_hit_way  = '0;
      w_any_free = 1'b0;
      w_free_way = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (w_cand[i] && (r_tag_ram[i] == r_latched_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = c_WAY_W'(i);
         end
         if (!r_valid[i]) begin
            w_any_free = 1'b1;
            w_free_way = c_WAY_W'(i);
         end
      end
      w_victim = w_any_free ? w_free_way : r_rr_ptr;
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= c_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:     if (!bus.flush && bus.req_valid) w_next_state = c_LOOKUP;
         c_LOOKUP:   w_next_state = w_hit ? c_RESP : c_MISS_REQ;
         c_MISS_REQ: if (bus.mem_ack) w_next_state = c_FILL;
         c_FILL:     w_next_state = c_RESP;
         c_RESP:     w_next_state = c_IDLE;
         default:    w_next_state = c_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid       <= '0;
         r_rr_ptr      <= '0;
         r_latched_tag <= '0;
         r_resp_hit    <= 1'b0;
         r_resp_way    <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (bus.flush) begin
                  r_valid  <= '0;
                  r_rr_ptr <= '0;
               end else if (bus.req_valid) begin
                  r_latched_tag <= bus.req_tag;
               end
            end
            c_LOOKUP: begin
               r_resp_hit <= w_hit;
               r_resp_way <= w_hit_way;
            end
            c_FILL: begin
               r_valid[w_victim] <= 1'b1;
               if (!w_any_free) r_rr_ptr <= r_rr_ptr + 1'b1;
               r_resp_hit <= 1'b0;
               r_resp_way <= w_victim;
            end
            default: ;
         endcase
      end
   end

   // Tag storage needs no reset: r_valid gates every use of it.
   always_ff @(posedge clk) begin
      if (!reset && (r_state == c_FILL)) r_tag_ram[w_victim] <= r_latched_tag;
   end

   always_comb begin
      bus.req_ready      = 1'b0;
      bus.halt_tag       = r_latched_tag[HALT_W-1:0];
      bus.we             = '0;
      bus.halt_tag_write = '0;
      bus.way_en         = '0;
      bus.resp_valid     = 1'b0;
      bus.resp_hit       = 1'b0;
      bus.resp_way       = '0;
      bus.mem_req        = 1'b0;
      bus.mem_tag        = '0;
      case (r_state)
         c_IDLE:     bus.req_ready = 1'b1;
         c_LOOKUP:   bus.way_en = w_cand;
         c_MISS_REQ: begin
            bus.mem_req = 1'b1;
            bus.mem_tag = r_latched_tag;
         end
         c_FILL: begin
            // Array captures on negedge; a reset this cycle must not write.
            bus.we[w_victim]   = !reset;
            bus.halt_tag_write = r_latched_tag[HALT_W-1:0];
         end
         c_RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_hit   = r_resp_hit;
            bus.resp_way   = r_resp_way;
         end
         default: ;
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_way_halt_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_way_halt_controller
// Brief    : Scoreboard bench with halt-array model and cache reference model
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_way_halt_controller;
   localparam int TAG_W  = 12;
   localparam int HALT_W = 4;
   localparam int WAYS   = 8;

   typedef struct {
      logic       hit;
      logic [2:0] way;
   } resp_t;

   typedef struct {
      logic [WAYS-1:0]   we;
      logic [HALT_W-1:0] ht;
   } wr_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   exp_resp_cycle = 0;

   resp_t resp_q[$];
   wr_t   wr_q[$];
   resp_t mon_r;
   wr_t   mon_w;

   logic [TAG_W-1:0]  m_tag [WAYS];
   bit                m_valid [WAYS];
   int                m_rr;
   logic [HALT_W-1:0] arr [WAYS];

   way_halt_controller_if #(.TAG_W(TAG_W), .HALT_W(HALT_W), .WAYS(WAYS)) bus ();

   way_halt_controller #(.TAG_W(TAG_W), .HALT_W(HALT_W), .WAYS(WAYS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Halt-tag array: resets to tag 0, captures writes on the falling edge.
   always @(negedge clk) begin
      for (int i = 0; i < WAYS; i++) begin
         if (reset)          arr[i] <= '0;
         else if (bus.we[i]) arr[i] <= bus.halt_tag_write;
      end
   end

   always_comb begin
      bus.halt_flag = '0;
      for (int i = 0; i < WAYS; i++) bus.halt_flag[i] = (arr[i] == bus.halt_tag);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (bus.resp_valid) begin
         if (resp_q.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
         end else begin
            mon_r = resp_q.pop_front();
            check("resp_hit", 32'(bus.resp_hit), 32'(mon_r.hit));
            check("resp_way", 32'(bus.resp_way), 32'(mon_r.way));
            check("resp_latency", 32'(cyc), 32'(exp_resp_cycle));
         end
      end
      if (bus.we != '0) begin
         if (wr_q.size() == 0) begin
            check("unexpected_we", 32'(bus.we), 32'd0);
         end else begin
            mon_w = wr_q.pop_front();
            check("we", 32'(bus.we), 32'(mon_w.we));
            check("halt_tag_write", 32'(bus.halt_tag_write), 32'(mon_w.ht));
         end
      end
   end

   task automatic model_clear();
      for (int i = 0; i < WAYS; i++) m_valid[i] = 1'b0;
      m_rr = 0;
   endtask

   task automatic do_req(input logic [TAG_W-1:0] tag, input int delay, input bit abort);
      logic [WAYS-1:0] en;
      bit              hit;
      int              way;
      int              vic;
      int              n;
      en  = '0;
      hit = 1'b0;
      way = 0;
      for (int i = 0; i < WAYS; i++)
         if (m_valid[i] && (m_tag[i][HALT_W-1:0] == tag[HALT_W-1:0])) en[i] = 1'b1;
      for (int i = WAYS - 1; i >= 0; i--)
         if (m_valid[i] && (m_tag[i] == tag)) begin
            hit = 1'b1;
            way = i;
         end

      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_tag   = tag;
      if (hit) begin
         exp_resp_cycle = cyc + 2;
         resp_q.push_back('{1'b1, 3'(way)});
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("way_en", 32'(bus.way_en), 32'(en));
      check("halt_tag", 32'(bus.halt_tag), 32'(tag[HALT_W-1:0]));
      check("lookup_mem_req", 32'(bus.mem_req), 32'd0);
      if (hit) begin
         @(negedge clk);
         check("hit_mem_req", 32'(bus.mem_req), 32'd0);
         return;
      end

      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.mem_req && n < 20);
      check("mem_req_seen", 32'(bus.mem_req), 32'd1);
      if (!bus.mem_req) return;
      check("mem_tag", 32'(bus.mem_tag), 32'(tag));

      if (abort) begin
         @(posedge clk); #1;
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
         model_clear();
         @(negedge clk);
         check("abort_mem_req", 32'(bus.mem_req), 32'd0);
         check("abort_req_ready", 32'(bus.req_ready), 32'd1);
         return;
      end

      repeat (delay) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("mem_req_hold", 32'(bus.mem_req), 32'd1);
         check("mem_tag_hold", 32'(bus.mem_tag), 32'(tag));
      end

      @(posedge clk); #1;
      bus.mem_ack = 1'b1;
      vic = -1;
      for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[i]) vic = i;
      if (vic < 0) begin
         vic  = m_rr;
         m_rr = (m_rr + 1) % WAYS;
      end
      m_tag[vic]   = tag;
      m_valid[vic] = 1'b1;
      wr_q.push_back('{WAYS'(1) << vic, tag[HALT_W-1:0]});
      resp_q.push_back('{1'b0, 3'(vic)});
      exp_resp_cycle = cyc + 2;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      @(negedge clk);
      check("fill_mem_req", 32'(bus.mem_req), 32'd0);
      @(posedge clk);
   endtask

   task automatic do_flush(input bit with_req);
      @(posedge clk); #1;
      bus.flush     = 1'b1;
      bus.req_valid = with_req;
      bus.req_tag   = 12'h555;
      @(posedge clk); #1;
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      model_clear();
      @(negedge clk);
      check("flush_req_ready", 32'(bus.req_ready), 32'd1);
      check("flush_way_en", 32'(bus.way_en), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [TAG_W-1:0] t;
      bus.req_valid = 1'b0;
      bus.req_tag   = '0;
      bus.flush     = 1'b0;
      bus.mem_ack   = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_we", 32'(bus.we), 32'd0);
      check("rst_way_en", 32'(bus.way_en), 32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_halt_tag", 32'(bus.halt_tag), 32'd0);

      // Invalid ways stay disabled even though every halt flag is set.
      do_req(12'h000, 0, 1'b0);

      do_flush(1'b0);
      do_req(12'h123, 0, 1'b0);
      do_req(12'h123, 0, 1'b0);

      do_flush(1'b0);
      do_req(12'h1A3, 0, 1'b0);
      do_req(12'h2B3, 1, 1'b0);
      do_req(12'h2B3, 0, 1'b0);
      do_req(12'h3C3, 0, 1'b0);

      do_flush(1'b0);
      for (int i = 0; i < WAYS; i++) do_req(12'h100 + 12'(i * 17), 0, 1'b0);
      do_req(12'h900, 0, 1'b0);
      do_req(12'h901, 2, 1'b0);
      do_req(12'h100, 0, 1'b0);

      do_req(12'h7E5, 5, 1'b0);
      @(posedge clk); #1;
      bus.mem_ack = 1'b1;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      @(negedge clk);
      check("stray_ack_req_ready", 32'(bus.req_ready), 32'd1);
      check("stray_ack_mem_req", 32'(bus.mem_req), 32'd0);

      do_req(12'hFFF, 0, 1'b1);
      do_req(12'h7E5, 0, 1'b0);
      do_flush(1'b1);
      do_req(12'h7E5, 0, 1'b0);

      for (int k = 0; k < 60; k++) begin
         t = (12'($urandom_range(0, 5)) << 4) | 12'($urandom_range(0, 3));
         do_req(t, int'($urandom_range(0, 3)), 1'b0);
      end

      repeat (4) @(posedge clk);
      check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
      check("write_queue_drained", 32'(wr_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
